// File: rtl/aec_expr_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aec_expr_tx : buffers and syntax-checks an AEC infix expression, then   |
// | streams it as ASCII to the calculator and captures its result.          |
// | Revision 1.0 - initial release                                          |
// +-----------------------------------------------------------------------+
module aec_expr_tx #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  input  logic [4:0] tok_code,
  output logic       tok_ready,
  input  logic       start,
  output logic [7:0] ascii_out,
  output logic       ready,
  input  logic       rx_valid,
  input  logic [6:0] rx_result,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] result
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEND = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;

  localparam logic [4:0] c_LPAR = 5'd20;
  localparam logic [4:0] c_RPAR = 5'd21;
  localparam logic [4:0] c_EQ   = 5'd25;

  logic [1:0]      r_state;
  logic [4:0]      r_count;
  logic [2:0]      r_depth;
  logic            r_bad;
  logic            r_eq_seen;
  logic            r_last_eq;
  logic            r_cur_eq;
  logic [c_AW-1:0] r_rd_ptr;
  logic [4:0]      r_buf [DEPTH];
  logic [7:0]      r_ascii;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [6:0]      r_result;

  logic            w_accept;
  logic            w_code_ok;
  logic            w_tok_bad;
  logic            w_reject;
  logic [4:0]      w_rd_code;
  logic [4:0]      w_first_code;

  function automatic logic [7:0] enc(input logic [4:0] code);
    logic [7:0] v;
    v = 8'h00;
    if (code <= 5'd9) begin
      v = 8'h30 + {3'b000, code};
    end else if (code <= 5'd15) begin
      v = 8'h61 + {3'b000, code} - 8'd10;
    end else begin
      case (code)
        5'd20:   v = 8'h28;
        5'd21:   v = 8'h29;
        5'd22:   v = 8'h2A;
        5'd23:   v = 8'h2B;
        5'd24:   v = 8'h2D;
        5'd25:   v = 8'h3D;
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  assign tok_ready    = (r_state == c_IDLE) && (32'(r_count) < DEPTH) && !start;
  assign w_accept     = tok_valid && tok_ready;
  assign w_code_ok    = (tok_code <= 5'd15) || ((tok_code >= 5'd20) && (tok_code <= 5'd25));
  assign w_tok_bad    = !w_code_ok || r_eq_seen ||
                        ((tok_code == c_RPAR) && (r_depth == 3'd0)) ||
                        ((tok_code == c_LPAR) && (r_depth == 3'd7));
  assign w_reject     = r_bad || (r_count == 5'd0) || (r_depth != 3'd0) || !r_last_eq;
  assign w_rd_code    = r_buf[r_rd_ptr];
  assign w_first_code = r_buf[0];

  // Storage carries no reset: contents are only read below count.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_count[c_AW-1:0]] <= tok_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_count   <= 5'd0;
      r_depth   <= 3'd0;
      r_bad     <= 1'b0;
      r_eq_seen <= 1'b0;
      r_last_eq <= 1'b0;
      r_cur_eq  <= 1'b0;
      r_rd_ptr  <= '0;
      r_ascii   <= 8'h00;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_result  <= 7'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (w_reject) begin
              r_err     <= 1'b1;
              r_count   <= 5'd0;
              r_depth   <= 3'd0;
              r_bad     <= 1'b0;
              r_eq_seen <= 1'b0;
              r_last_eq <= 1'b0;
            end else begin
              // First character is presented in the cycle SEND is entered.
              r_state  <= c_SEND;
              r_busy   <= 1'b1;
              r_ready  <= 1'b1;
              r_ascii  <= enc(w_first_code);
              r_cur_eq <= (w_first_code == c_EQ);
              r_rd_ptr <= c_AW'(1);
            end
          end else if (w_accept) begin
            r_count   <= r_count + 5'd1;
            r_last_eq <= (tok_code == c_EQ);
            if (tok_code == c_EQ) r_eq_seen <= 1'b1;
            if (w_tok_bad) r_bad <= 1'b1;
            if (tok_code == c_LPAR) r_depth <= r_depth + 3'd1;
            else if (tok_code == c_RPAR) r_depth <= r_depth - 3'd1;
          end
        end
        c_SEND: begin
          if (r_cur_eq) begin
            r_state <= c_WAIT;
            r_ready <= 1'b0;
            r_ascii <= 8'h00;
          end else begin
            r_ready  <= 1'b1;
            r_ascii  <= enc(w_rd_code);
            r_cur_eq <= (w_rd_code == c_EQ);
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        c_WAIT: begin
          if (rx_valid) begin
            r_result  <= rx_result;
            r_done    <= 1'b1;
            r_state   <= c_IDLE;
            r_busy    <= 1'b0;
            r_count   <= 5'd0;
            r_depth   <= 3'd0;
            r_bad     <= 1'b0;
            r_eq_seen <= 1'b0;
            r_last_eq <= 1'b0;
            r_cur_eq  <= 1'b0;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_ascii <= 8'h00;
        end
      endcase
    end
  end

  assign ascii_out = r_ascii;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_aec_expr_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_aec_expr_tx : directed self-checking bench for aec_expr_tx.          |
// | Revision 1.0 - initial release                                          |
// +-----------------------------------------------------------------------+
module tb_aec_expr_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tok_valid;
  logic [4:0] tok_code;
  logic       tok_ready;
  logic       start;
  logic [7:0] ascii_out;
  logic       ready;
  logic       rx_valid;
  logic [6:0] rx_result;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aec_expr_tx #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok_code  (tok_code),
    .tok_ready (tok_ready),
    .start     (start),
    .ascii_out (ascii_out),
    .ready     (ready),
    .rx_valid  (rx_valid),
    .rx_result (rx_result),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [4:0] codes[$]);
    foreach (codes[i]) begin
      tok_code  = codes[i];
      tok_valid = 1'b1;
      tick();
    end
    tok_valid = 1'b0;
  endtask

  task automatic send_expect(input logic [7:0] chars[$], input logic [6:0] res);
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (chars[i]) begin
      chk("ready", ready, 1);
      chk("ascii", ascii_out, chars[i]);
      chk("busy", busy, 1);
      tick();
    end
    chk("ready_end", ready, 0);
    chk("ascii_end", ascii_out, 0);
    rx_valid  = 1'b1;
    rx_result = res;
    tick();
    rx_valid = 1'b0;
    chk("done", done, 1);
    chk("result", result, res);
    chk("busy_after", busy, 0);
    chk("tok_ready_after", tok_ready, 1);
    tick();
    chk("done_pulse", done, 0);
  endtask

  task automatic expect_reject(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_err"}, err, 1);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_busy"}, busy, 0);
    tick();
    chk({tag, "_err_pulse"}, err, 0);
    chk({tag, "_ready2"}, ready, 0);
    chk({tag, "_tok_ready"}, tok_ready, 1);
  endtask

  initial begin
    logic [4:0] codes[$];
    logic [7:0] chars[$];

    rst = 1'b1; tok_valid = 1'b0; tok_code = 5'd0; start = 1'b0;
    rx_valid = 1'b0; rx_result = 7'd0;
    #12;
    chk("rst_ascii", ascii_out, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_tok_ready", tok_ready, 1);
    rst = 1'b0;
    tick();

    // Happy path: 3+4*(2-1)=
    codes = '{5'd3, 5'd23, 5'd4, 5'd22, 5'd20, 5'd2, 5'd24, 5'd1, 5'd21, 5'd25};
    push_seq(codes);
    chars = '{8'h33, 8'h2B, 8'h34, 8'h2A, 8'h28, 8'h32, 8'h2D, 8'h31, 8'h29, 8'h3D};
    send_expect(chars, 7'd7);

    // Hex digits: a+f=
    codes = '{5'd10, 5'd23, 5'd15, 5'd25};
    push_seq(codes);
    chars = '{8'h61, 8'h2B, 8'h66, 8'h3D};
    send_expect(chars, 7'd25);

    // Rejects
    codes = '{5'd20, 5'd3, 5'd23, 5'd4, 5'd25};
    push_seq(codes);
    expect_reject("unbal");
    codes = '{5'd3, 5'd23, 5'd4};
    push_seq(codes);
    expect_reject("noeq");
    expect_reject("empty");
    codes = '{5'd18, 5'd25};
    push_seq(codes);
    expect_reject("code18");
    codes = '{5'd3, 5'd25, 5'd4};
    push_seq(codes);
    expect_reject("after_eq");

    // Buffer must be empty after the rejects
    codes = '{5'd3, 5'd23, 5'd6, 5'd25};
    push_seq(codes);
    chars = '{8'h33, 8'h2B, 8'h36, 8'h3D};
    send_expect(chars, 7'd9);

    // Full buffer: 1+2+...+8= then a 17th token
    codes = '{5'd1, 5'd23, 5'd2, 5'd23, 5'd3, 5'd23, 5'd4, 5'd23,
              5'd5, 5'd23, 5'd6, 5'd23, 5'd7, 5'd23, 5'd8, 5'd25, 5'd9};
    tok_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tok_code = codes[i];
      #1;
      if (i == 16) chk("full_tok_ready17", tok_ready, 0);
      else if (i == 0 || i == 15) chk("full_tok_ready", tok_ready, 1);
      tick();
    end
    tok_valid = 1'b0;
    chars = '{8'h31, 8'h2B, 8'h32, 8'h2B, 8'h33, 8'h2B, 8'h34, 8'h2B,
              8'h35, 8'h2B, 8'h36, 8'h2B, 8'h37, 8'h2B, 8'h38, 8'h3D};
    send_expect(chars, 7'd36);

    // rx_valid during SEND ignored, start during WAIT ignored
    codes = '{5'd1, 5'd23, 5'd2, 5'd25};
    push_seq(codes);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hs_first", ascii_out, 8'h31);
    rx_valid = 1'b1; rx_result = 7'd99;
    tick();
    rx_valid = 1'b0;
    chk("hs_send_done", done, 0);
    chk("hs_send_result", result, 36);
    chk("hs_second", ascii_out, 8'h2B);
    tick(); tick(); tick();
    chk("hs_wait_ready", ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hs_wait_busy", busy, 1);
    chk("hs_wait_err", err, 0);
    chk("hs_wait_ready2", ready, 0);
    rx_valid = 1'b1; rx_result = 7'd3;
    tick();
    rx_valid = 1'b0;
    chk("hs_done", done, 1);
    chk("hs_result", result, 3);
    tick();

    // start and tok_valid together: token not taken
    codes = '{5'd5, 5'd23, 5'd6, 5'd25};
    push_seq(codes);
    tok_valid = 1'b1; tok_code = 5'd7; start = 1'b1;
    #1;
    chk("both_tok_ready", tok_ready, 0);
    tick();
    tok_valid = 1'b0; start = 1'b0;
    chars = '{8'h35, 8'h2B, 8'h36, 8'h3D};
    foreach (chars[i]) begin
      chk("both_ascii", ascii_out, chars[i]);
      tick();
    end
    chk("both_ready_end", ready, 0);
    rx_valid = 1'b1; rx_result = 7'd11;
    tick();
    rx_valid = 1'b0;
    chk("both_result", result, 11);
    tick();

    // Async reset mid-SEND after the third character
    codes = '{5'd3, 5'd23, 5'd4, 5'd22, 5'd20, 5'd2, 5'd24, 5'd1, 5'd21, 5'd25};
    push_seq(codes);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("ar_third", ascii_out, 8'h34);
    #2 rst = 1'b1;
    #1;
    chk("ar_ready", ready, 0);
    chk("ar_ascii", ascii_out, 0);
    chk("ar_busy", busy, 0);
    chk("ar_result", result, 0);
    chk("ar_tok_ready", tok_ready, 1);
    #1 rst = 1'b0;
    tick();
    codes = '{5'd9, 5'd24, 5'd2, 5'd25};
    push_seq(codes);
    chars = '{8'h39, 8'h2D, 8'h32, 8'h3D};
    send_expect(chars, 7'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
